// File: rtl/nn_host_sequencer.sv
// Command-stream bus initiator for the NN accelerator slave port.
// Each command becomes at most one bus cycle and yields exactly one response.
module nn_host_sequencer #(
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [19:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic [19:0] bus_addr,
    output logic [31:0] bus_din,
    output logic        bus_RW,
    output logic        bus_sel,
    input  logic [31:0] bus_dout,
    input  logic        bus_pushout,
    input  logic        bus_stop,
    output logic [15:0] done_cnt
);

    localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_XFER    = 3'd2;
    localparam logic [2:0] S_RSP     = 3'd3;
    localparam logic [2:0] S_WAITING = 3'd4;

    localparam logic [1:0] OP_WR    = 2'd0;
    localparam logic [1:0] OP_RD    = 2'd1;
    localparam logic [1:0] OP_START = 2'd2;
    localparam logic [1:0] OP_WAIT  = 2'd3;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_BADADDR = 2'd2;

    logic [2:0]     state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [19:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [2:0]     lat_q, lat_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           done_seen_q, done_seen_d;
    logic [15:0]    done_cnt_q, done_cnt_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [31:0]    rsp_data_q, rsp_data_d;
    logic [1:0]     rsp_status_q, rsp_status_d;
    logic [19:0]    bus_addr_q, bus_addr_d;
    logic [31:0]    bus_din_q, bus_din_d;
    logic           bus_rw_q, bus_rw_d;
    logic           bus_sel_q, bus_sel_d;
    logic           cmd_bad;

    assign cmd_ready = (state_q == S_IDLE) && !rsp_valid_q && !reset;
    // Addresses between the registers and config memory map to nothing on the slave.
    assign cmd_bad   = ((cmd_op == OP_WR) || (cmd_op == OP_RD)) &&
                       (cmd_addr >= 20'd3) && (cmd_addr <= 20'h1FFFF);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lat_d        = lat_q;
        wcnt_d       = wcnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        bus_addr_d   = bus_addr_q;
        bus_din_d    = bus_din_q;
        bus_rw_d     = bus_rw_q;
        bus_sel_d    = bus_sel_q;
        done_seen_d  = done_seen_q | bus_pushout;
        done_cnt_d   = done_cnt_q + 16'(bus_pushout);
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wcnt_d  = '0;
                    if (cmd_bad) begin
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_BADADDR;
                        rsp_data_d   = '0;
                        state_d      = S_RSP;
                    end else if (cmd_op == OP_WAIT) begin
                        if (done_seen_q) begin
                            rsp_valid_d  = 1'b1;
                            rsp_status_d = ST_OK;
                            rsp_data_d   = '0;
                            done_seen_d  = 1'b0;
                            state_d      = S_RSP;
                        end else begin
                            state_d = S_WAITING;
                        end
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!bus_stop) begin
                    bus_sel_d  = 1'b1;
                    bus_rw_d   = (op_q != OP_RD);
                    bus_addr_d = (op_q == OP_START) ? 20'd2 : addr_q;
                    bus_din_d  = (op_q == OP_START) ? 32'hACE :
                                 (op_q == OP_WR)    ? wdata_q : 32'd0;
                    lat_d      = '0;
                    // A pushout on this same edge belongs to the previous run.
                    if (op_q == OP_START) done_seen_d = 1'b0;
                    state_d    = S_XFER;
                end
            end
            S_XFER: begin
                if ((op_q != OP_RD) || (lat_q == 3'(RD_LAT))) begin
                    bus_sel_d    = 1'b0;
                    bus_rw_d     = 1'b0;
                    bus_addr_d   = '0;
                    bus_din_d    = '0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_OK;
                    rsp_data_d   = (op_q == OP_RD) ? bus_dout : 32'd0;
                    state_d      = S_RSP;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            S_WAITING: begin
                if (bus_pushout || done_seen_q) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_OK;
                    rsp_data_d   = '0;
                    done_seen_d  = 1'b0;
                    state_d      = S_RSP;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                    if (wcnt_q == WCW'(TIMEOUT - 1)) begin
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_TIMEOUT;
                        rsp_data_d   = '0;
                        state_d      = S_RSP;
                    end
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lat_q        <= '0;
            wcnt_q       <= '0;
            done_seen_q  <= 1'b0;
            done_cnt_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            bus_addr_q   <= '0;
            bus_din_q    <= '0;
            bus_rw_q     <= 1'b0;
            bus_sel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lat_q        <= lat_d;
            wcnt_q       <= wcnt_d;
            done_seen_q  <= done_seen_d;
            done_cnt_q   <= done_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            bus_addr_q   <= bus_addr_d;
            bus_din_q    <= bus_din_d;
            bus_rw_q     <= bus_rw_d;
            bus_sel_q    <= bus_sel_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign bus_addr   = bus_addr_q;
    assign bus_din    = bus_din_q;
    assign bus_RW     = bus_rw_q;
    assign bus_sel    = bus_sel_q;
    assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_nn_host_sequencer.sv
// Bench for nn_host_sequencer: directed steps plus random commands against a
// transaction-level model of responses, latencies, bus cycles and done tracking.
module tb_nn_host_sequencer;

    localparam int RD_LAT = 1;
    localparam int TO     = 16;

    localparam logic [1:0] OP_WR    = 2'd0;
    localparam logic [1:0] OP_RD    = 2'd1;
    localparam logic [1:0] OP_START = 2'd2;
    localparam logic [1:0] OP_WAIT  = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [19:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic [19:0] bus_addr;
    logic [31:0] bus_din;
    logic        bus_RW;
    logic        bus_sel;
    logic [31:0] bus_dout;
    logic        bus_pushout = 1'b0;
    logic        bus_stop = 1'b0;
    logic [15:0] done_cnt;

    int checks = 0;
    int errors = 0;

    // Slave/monitor state
    int          sel_cnt = 0;
    int          sel_run = 0;
    logic [19:0] last_addr = '0;
    logic [31:0] last_din = '0;
    logic        last_rw = 1'b0;
    logic [31:0] rd_val = '0;

    // Reference model state
    bit m_ds = 1'b0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    nn_host_sequencer #(.RD_LAT(RD_LAT), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status),
        .bus_addr(bus_addr), .bus_din(bus_din), .bus_RW(bus_RW), .bus_sel(bus_sel),
        .bus_dout(bus_dout), .bus_pushout(bus_pushout), .bus_stop(bus_stop),
        .done_cnt(done_cnt)
    );

    // Slave: read data is only valid in the final cycle of a read strobe.
    always @(negedge clk) begin
        if (bus_sel) begin
            sel_cnt   = sel_cnt + 1;
            sel_run   = sel_run + 1;
            last_addr = bus_addr;
            last_din  = bus_din;
            last_rw   = bus_RW;
        end else begin
            sel_run = 0;
        end
        bus_dout = (bus_sel && !bus_RW && sel_run == RD_LAT + 1) ? rd_val : ~rd_val;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // p = cycle index after accept at which a one-cycle pushout is driven (<1: none)
    task automatic run_cmd(input logic [1:0] op, input logic [19:0] addr, input logic [31:0] wd,
                           input logic [31:0] rv, input int stop, input int rdy, input int p);
        logic [1:0]  es, gs;
        logic [31:0] ed, gd, edin;
        logic [19:0] ea;
        logic        erw;
        int          elat, esel, lat, rlat, hold, base, n;
        bit          got, hs, bad;
        es = 2'd0; ed = '0; esel = 0; ea = addr; edin = '0; erw = 1'b0; elat = 0;
        rd_val = rv;
        bad = ((op == OP_WR) || (op == OP_RD)) && (addr >= 20'd3) && (addr <= 20'h1FFFF);
        if (bad) begin
            es = 2'd2; elat = 1;
            if (p >= 1) m_ds = 1'b1;
        end else begin
            case (op)
                OP_WR: begin
                    elat = stop + 3; esel = 1; edin = wd; erw = 1'b1;
                    if (p >= 1) m_ds = 1'b1;
                end
                OP_RD: begin
                    elat = stop + RD_LAT + 3; esel = RD_LAT + 1; ed = rv;
                    if (p >= 1) m_ds = 1'b1;
                end
                OP_START: begin
                    elat = stop + 3; esel = 1; ea = 20'd2; edin = 32'hACE; erw = 1'b1;
                    m_ds = (p > stop + 1);
                end
                default: begin
                    if (m_ds) begin
                        elat = 1; m_ds = (p >= 1);
                    end else if (p >= 1 && p <= TO) begin
                        elat = p + 1; m_ds = 1'b0;
                    end else begin
                        es = 2'd1; elat = TO + 1; m_ds = (p >= 1);
                    end
                end
            endcase
        end
        if (p >= 1) m_cnt++;

        base = sel_cnt;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        bus_stop = (stop > 0); bus_pushout = 1'b0;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'($urandom()); cmd_addr = 20'($urandom()); cmd_wdata = $urandom();
        lat = 1; got = 1'b0; hs = 1'b0; hold = 0; rlat = 0; gd = '0; gs = '0;
        while (!(hs && lat > p) && lat < 200) begin
            bus_stop = (lat <= stop);
            bus_pushout = (lat == p);
            if (!got) begin
                if (rsp_valid) begin
                    got = 1'b1; rlat = lat; gd = rsp_data; gs = rsp_status;
                end else begin
                    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
                end
            end
            if (got && !hs) begin
                if (rsp_ready) begin
                    hs = 1'b1; rsp_ready = 1'b0;
                    chk("rsp_drop", 32'(rsp_valid), 32'd0);
                    chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
                end else begin
                    if (hold > 0) begin
                        chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                        chk("rsp_hold_data", rsp_data, ed);
                        chk("rsp_hold_cmd_ready", 32'(cmd_ready), 32'd0);
                    end
                    if (hold == rdy) rsp_ready = 1'b1;
                    hold++;
                end
            end
            @(negedge clk);
            lat++;
        end
        bus_stop = 1'b0; bus_pushout = 1'b0; rsp_ready = 1'b0;
        chk("rsp_seen", 32'(got), 32'd1);
        chk("rsp_status", 32'(gs), 32'(es));
        chk("rsp_data", gd, ed);
        chk("rsp_latency", 32'(rlat), 32'(elat));
        chk("sel_cycles", 32'(sel_cnt - base), 32'(esel));
        if (esel > 0) begin
            chk("bus_addr", 32'(last_addr), 32'(ea));
            chk("bus_din", last_din, edin);
            chk("bus_rw", 32'(last_rw), 32'(erw));
        end
        chk("bus_idle_ctl", 32'({bus_sel, bus_RW, bus_addr}), 32'd0);
        chk("bus_idle_din", bus_din, 32'd0);
        chk("done_cnt", 32'(done_cnt), 32'(16'(m_cnt)));
    endtask

    initial begin
        int n;
        logic [1:0]  op;
        logic [19:0] addr;
        int p;

        // Reset state
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_bus_ctl", 32'({bus_sel, bus_RW, bus_addr}), 32'd0);
        chk("rst_bus_din", bus_din, 32'd0);
        chk("rst_done_cnt", 32'(done_cnt), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Basic write, read, back-pressured write
        run_cmd(OP_WR, 20'h40005, 32'h00FFFFFE, 32'h0, 0, 0, -1);
        run_cmd(OP_RD, 20'h20010, 32'h0, 32'h12345678, 0, 0, -1);
        run_cmd(OP_WR, 20'h40123, 32'hCAFEF00D, 32'h0, 5, 1, -1);
        run_cmd(OP_RD, 20'h7FFF0, 32'h0, 32'hA5A5_0F0F, 3, 2, -1);

        // Run launch and completion
        run_cmd(OP_START, 20'h0, 32'h0, 32'h0, 0, 3, -1);
        run_cmd(OP_WAIT, 20'h0, 32'h0, 32'h0, 0, 0, 12);
        run_cmd(OP_WAIT, 20'h0, 32'h0, 32'h0, 2, 0, -1);

        // Address decode boundaries
        run_cmd(OP_RD, 20'h00100, 32'h0, 32'h1111, 0, 0, -1);
        run_cmd(OP_WR, 20'h00003, 32'h5, 32'h0, 0, 0, -1);
        run_cmd(OP_RD, 20'h1FFFF, 32'h0, 32'h2222, 0, 1, -1);
        run_cmd(OP_WR, 20'h20000, 32'h77, 32'h0, 0, 0, -1);
        run_cmd(OP_RD, 20'h00002, 32'h0, 32'h3333, 0, 0, -1);
        run_cmd(OP_WR, 20'h00000, 32'h99, 32'h0, 1, 0, -1);

        // Pushout coinciding with START issue is stale; later ones count
        run_cmd(OP_START, 20'h0, 32'h0, 32'h0, 0, 0, 1);
        run_cmd(OP_WAIT, 20'h0, 32'h0, 32'h0, 0, 0, -1);
        run_cmd(OP_START, 20'h0, 32'h0, 32'h0, 2, 0, 5);
        run_cmd(OP_WAIT, 20'h0, 32'h0, 32'h0, 0, 1, -1);
        run_cmd(OP_WR, 20'h40000, 32'h1, 32'h0, 0, 0, 1);
        run_cmd(OP_WAIT, 20'h0, 32'h0, 32'h0, 0, 0, -1);
        run_cmd(OP_WAIT, 20'h0, 32'h0, 32'h0, 0, 0, TO);
        run_cmd(OP_WAIT, 20'h0, 32'h0, 32'h0, 0, 2, TO + 1);
        run_cmd(OP_WAIT, 20'h0, 32'h0, 32'h0, 0, 0, -1);

        // Random commands
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: addr = 20'($urandom_range(0, 2));
                1: addr = 20'($urandom_range(3, 32'h1FFFF));
                2: addr = 20'($urandom_range(32'h20000, 32'h3FFFF));
                default: addr = 20'($urandom_range(32'h40000, 32'hFFFFF));
            endcase
            if (op == OP_WAIT)
                p = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 24));
            else
                p = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : -1;
            run_cmd(op, addr, $urandom(), $urandom(), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), p);
        end

        // Reset in the middle of a read
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_RD; cmd_addr = 20'h40010; rd_val = 32'hDEAD_BEEF;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!bus_sel && n < 20) begin @(negedge clk); n++; end
        chk("rst_mid_sel_before", 32'(bus_sel), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_sel_drop", 32'(bus_sel), 32'd0);
        chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_mid_done_cnt", 32'(done_cnt), 32'd0);
        m_ds = 1'b0; m_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        run_cmd(OP_WR, 20'h50000, 32'h0BAD_CAFE, 32'h0, 0, 0, -1);
        run_cmd(OP_WAIT, 20'h0, 32'h0, 32'h0, 0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
